// File: rtl/div_array_if.sv
// div_array_if: request/response bundle for the matrix divider.
// master issues operands and start, slave returns quotients.
interface div_array_if #(
  parameter int n = 6
);
  logic                      start;
  logic [n-1:0][n-1:0][26:0] dataa;
  logic [n-1:0][n-1:0][26:0] datab;
  logic                      busy;
  logic                      done;
  logic [n-1:0][n-1:0][26:0] result;
  logic [n-1:0][n-1:0]       div_zero;

  modport master (
    output start, dataa, datab,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, dataa, datab,
    output busy, done, result, div_zero
  );
endinterface

// File: rtl/div_array.sv
// div_array: element-wise signed Q10.16 matrix divider.
// One shared controller drives n*n restoring radix-2 lanes.
module div_array #(
  parameter int n    = 6,
  parameter int FRAC = 16
) (
  input logic        clk,
  input logic        reset,
  div_array_if.slave bus
);
  localparam int W  = 27;
  localparam int QW = W + FRAC + 1;
  localparam int CW = $clog2(QW);
  localparam logic [W-1:0] QMAX =
    {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] QNEG =
    {1'b1, {(W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND
  } state_t;

  typedef logic [n-1:0][n-1:0]          flag_t;
  typedef logic [n-1:0][n-1:0][W-1:0]  word_t;
  typedef logic [n-1:0][n-1:0][QW-1:0] quo_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  flag_t         sa;
  flag_t         sb;
  flag_t         az;
  flag_t         bz;
  flag_t         qbit;
  flag_t         dz_q;
  word_t         ma;
  word_t         mb;
  word_t         rem;
  word_t         rem_nx;
  word_t         res_nx;
  word_t         res_q;
  quo_t          quo;
  logic          done_q;

  function automatic logic [W-1:0] mag(
    input logic [W-1:0] x
  );
    return x[W-1] ? -x : x;
  endfunction

  // The stored remainder is always below the
  // divisor, so it fits W bits; the shifted
  // working value needs one extra bit.
  function automatic logic [W:0] step(
    input logic [W-1:0] r,
    input logic         b,
    input logic [W-1:0] d
  );
    logic [W:0] s;
    s = {r, b};
    if (s >= {1'b0, d})
      return {1'b1, s[W-1:0] - d};
    return {1'b0, s[W-1:0]};
  endfunction

  // Q carries one extra fraction bit; halving
  // with the dropped bit added back rounds half
  // away from zero on the magnitude.
  function automatic logic [W-1:0] fin(
    input logic [QW-1:0] q,
    input logic          neg,
    input logic          zb,
    input logic          an,
    input logic          za
  );
    logic [QW-1:0] h;
    logic [W-1:0]  m;
    h = {1'b0, q[QW-1:1]} + QW'(q[0]);
    m = (h > QW'(QMAX)) ? QMAX : h[W-1:0];
    if (zb)
      return za ? '0 : (an ? QNEG : QMAX);
    return neg ? -m : m;
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state sequencing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = DIV;
      DIV:     if (cnt == '0) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // per-lane iteration step and final rounding
  always_comb begin
    qbit   = '0;
    rem_nx = '0;
    res_nx = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        {qbit[i][j], rem_nx[i][j]} =
          step(rem[i][j], ma[i][j][W-1],
               mb[i][j]);
        res_nx[i][j] =
          fin(quo[i][j],
              sa[i][j] ^ sb[i][j],
              bz[i][j], sa[i][j], az[i][j]);
      end
    end
  end

  // operand capture, iteration and result write
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      az     <= '0;
      bz     <= '0;
      ma     <= '0;
      mb     <= '0;
      rem    <= '0;
      quo    <= '0;
      res_q  <= '0;
      dz_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt <= CW'(QW - 1);
            rem <= '0;
            quo <= '0;
            for (int i = 0; i < n; i++) begin
              for (int j = 0; j < n; j++) begin
                sa[i][j] <= bus.dataa[i][j][W-1];
                sb[i][j] <= bus.datab[i][j][W-1];
                az[i][j] <= bus.dataa[i][j] == '0;
                bz[i][j] <= bus.datab[i][j] == '0;
                ma[i][j] <= mag(bus.dataa[i][j]);
                mb[i][j] <= mag(bus.datab[i][j]);
              end
            end
          end
        end
        DIV: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          rem <= rem_nx;
          for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
              ma[i][j] <=
                {ma[i][j][W-2:0], 1'b0};
              quo[i][j] <=
                {quo[i][j][QW-2:0], qbit[i][j]};
            end
          end
        end
        ROUND: begin
          res_q  <= res_nx;
          dz_q   <= bz;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = state != IDLE;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.div_zero = dz_q;
endmodule
